// File: rtl/alu181_pkg.sv
// Shared types and constants for the nibble-serial 74181 datapath.
package alu181_pkg;

  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned MAX_NIBBLES = 8;

  localparam logic CN4_RST = 1'b1;
  localparam logic EQ_RST  = 1'b0;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } state;

endpackage

// File: rtl/alu_74181.sv
// Combinational 74181 4-bit ALU slice, active-high data, active-low carries.
module alu_74181
  import alu181_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic [3:0]          s_i,
  input  logic                m_i,
  input  logic                cn_i,
  output logic [NIBBLE_W-1:0] f_o,
  output logic                cn4_o,
  output logic                aeqb_o,
  output logic                p_o,
  output logic                g_o
);

  logic [NIBBLE_W-1:0] prop;
  logic [NIBBLE_W-1:0] gen;

  always_comb begin
    logic c;
    logic gg;
    prop = '0;
    gen  = '0;
    f_o  = '0;
    c    = ~cn_i;
    gg   = 1'b0;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      prop[i] = a_i[i] | (b_i[i] & s_i[0]) | (~b_i[i] & s_i[1]);
      gen[i]  = (a_i[i] & ~b_i[i] & s_i[2]) | (a_i[i] & b_i[i] & s_i[3]);
      // gen is a subset of prop, so prop&~gen is the half-sum of prop+gen
      f_o[i]  = m_i ? ~(prop[i] & ~gen[i]) : ((prop[i] & ~gen[i]) ^ c);
      c       = gen[i] | (prop[i] & c);
      gg      = gen[i] | (prop[i] & gg);
    end
    cn4_o  = ~c;
    g_o    = ~gg;
    p_o    = ~(&prop);
    aeqb_o = &f_o;
  end

endmodule

// File: rtl/alu181_serial.sv
// Nibble-serial 74181 ALU: one slice per clock, carry held in a flop.
// Optional `ALU181_ZERO_EN adds a registered zero-result output.
module alu181_serial
  import alu181_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic [3:0]                    s,
  input  logic                          m,
  input  logic                          cn,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   f,
  output logic                          cn4,
  output logic                          equal
`ifdef ALU181_ZERO_EN
  ,
  output logic                          zero
`endif
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  generate
    if (NIBBLES < 1 || NIBBLES > MAX_NIBBLES) begin : g_bad_nibbles
      $error("alu181_serial: NIBBLES out of range 1..8");
    end
  endgenerate

  state             state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             eq_q, eq_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic [W-1:0]     f_q, f_d;
  logic             cn4_q, cn4_d;
  logic             equal_q, equal_d;
  logic             done_q, done_d;
`ifdef ALU181_ZERO_EN
  logic             zero_q, zero_d;
`endif

  logic [NIBBLE_W-1:0] a_nib, b_nib, sl_f;
  logic                sl_cn4, sl_aeqb;
  logic [W-1:0]        acc_upd;

  always_comb begin
    a_nib   = '0;
    b_nib   = '0;
    acc_upd = acc_q;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib                        = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib                        = b_q[i*NIBBLE_W +: NIBBLE_W];
        acc_upd[i*NIBBLE_W +: NIBBLE_W] = sl_f;
      end
    end
  end

  alu_74181 u_slice (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .s_i    (s_q),
    .m_i    (m_q),
    .cn_i   (carry_q),
    .f_o    (sl_f),
    .cn4_o  (sl_cn4),
    .aeqb_o (sl_aeqb),
    .p_o    (),
    .g_o    ()
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    f_d     = f_q;
    cn4_d   = cn4_q;
    equal_d = equal_q;
    done_d  = 1'b0;
`ifdef ALU181_ZERO_EN
    zero_d  = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          carry_d = cn;
          idx_d   = '0;
          eq_d    = 1'b1;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_upd;
        carry_d = sl_cn4;
        eq_d    = eq_q & sl_aeqb;
        // Results are published from the updated accumulator in the same edge
        if (idx_q == LAST) begin
          f_d     = acc_upd;
          cn4_d   = sl_cn4;
          equal_d = eq_q & sl_aeqb;
`ifdef ALU181_ZERO_EN
          zero_d  = (acc_upd == '0);
`endif
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b1;
      eq_q    <= 1'b1;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      f_q     <= '0;
      cn4_q   <= CN4_RST;
      equal_q <= EQ_RST;
      done_q  <= 1'b0;
`ifdef ALU181_ZERO_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      f_q     <= f_d;
      cn4_q   <= cn4_d;
      equal_q <= equal_d;
      done_q  <= done_d;
`ifdef ALU181_ZERO_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign f     = f_q;
  assign cn4   = cn4_q;
  assign equal = equal_q;
`ifdef ALU181_ZERO_EN
  assign zero  = zero_q;
`endif

endmodule

// File: tb/tb_alu181_serial.sv
// Randomised self-checking bench for alu181_serial at NIBBLES = 4, 1 and 8.
module tb_alu181_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [3:0]  s;
  logic        m, cn;
  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        cn4_v   [3];
  logic        eq_v    [3];
  logic [31:0] f_v     [3];
  logic [31:0] last_f  [3];
  logic [15:0] f4;
  logic [3:0]  f1;
  logic [31:0] f8;
`ifdef ALU181_ZERO_EN
  logic        zero_v  [3];
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  alu181_serial #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a[15:0]), .b(b[15:0]),
    .s(s), .m(m), .cn(cn), .busy(busy_v[0]), .done(done_v[0]), .f(f4),
    .cn4(cn4_v[0]), .equal(eq_v[0])
`ifdef ALU181_ZERO_EN
    , .zero(zero_v[0])
`endif
  );

  alu181_serial #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a[3:0]), .b(b[3:0]),
    .s(s), .m(m), .cn(cn), .busy(busy_v[1]), .done(done_v[1]), .f(f1),
    .cn4(cn4_v[1]), .equal(eq_v[1])
`ifdef ALU181_ZERO_EN
    , .zero(zero_v[1])
`endif
  );

  alu181_serial #(.NIBBLES(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b),
    .s(s), .m(m), .cn(cn), .busy(busy_v[2]), .done(done_v[2]), .f(f8),
    .cn4(cn4_v[2]), .equal(eq_v[2])
`ifdef ALU181_ZERO_EN
    , .zero(zero_v[2])
`endif
  );

  assign f_v[0] = {16'h0, f4};
  assign f_v[1] = {28'h0, f1};
  assign f_v[2] = f8;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned nib(input int unsigned w);
    case (w)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] wmask(input int unsigned n);
    longint unsigned mk;
    mk = (64'd1 << (4 * n)) - 64'd1;
    return mk[31:0];
  endfunction

  // Datasheet function table: arithmetic rows as X plus Y plus carry,
  // logic rows as the listed boolean. Returns {cn4, f}.
  function automatic logic [32:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic [3:0] sv, input logic mv,
                                        input logic cnv, input int unsigned n);
    longint unsigned mk, aa, bb, nb, x, y, sum, lg, res;
    mk = (64'd1 << (4 * n)) - 64'd1;
    aa = 64'(av) & mk;
    bb = 64'(bv) & mk;
    nb = ~bb & mk;
    case (sv)
      4'd0:    begin x = aa;       y = 0;        lg = ~aa;        end
      4'd1:    begin x = aa | bb;  y = 0;        lg = ~(aa | bb); end
      4'd2:    begin x = aa | nb;  y = 0;        lg = ~aa & bb;   end
      4'd3:    begin x = 0;        y = mk;       lg = 0;          end
      4'd4:    begin x = aa;       y = aa & nb;  lg = ~(aa & bb); end
      4'd5:    begin x = aa | bb;  y = aa & nb;  lg = nb;         end
      4'd6:    begin x = aa;       y = nb;       lg = aa ^ bb;    end
      4'd7:    begin x = aa & nb;  y = mk;       lg = aa & nb;    end
      4'd8:    begin x = aa;       y = aa & bb;  lg = ~aa | bb;   end
      4'd9:    begin x = aa;       y = bb;       lg = ~(aa ^ bb); end
      4'd10:   begin x = aa | nb;  y = aa & bb;  lg = bb;         end
      4'd11:   begin x = aa & bb;  y = mk;       lg = aa & bb;    end
      4'd12:   begin x = aa;       y = aa;       lg = mk;         end
      4'd13:   begin x = aa | bb;  y = aa;       lg = aa | nb;    end
      4'd14:   begin x = aa | nb;  y = aa;       lg = aa | bb;    end
      default: begin x = aa;       y = mk;       lg = aa;         end
    endcase
    sum = x + y + (cnv ? 64'd0 : 64'd1);
    res = mv ? (lg & mk) : (sum & mk);
    return {~sum[4*n], res[31:0]};
  endfunction

  // Called on a falling edge; returns on the falling edge where done is seen.
  task automatic do_op(input int unsigned w, input logic [31:0] av, input logic [31:0] bv,
                       input logic [3:0] sv, input logic mv, input logic cnv, input bit poke);
    int unsigned n, cyc, busy_cnt, extra;
    logic [32:0] r;
    logic [31:0] mk;
    bit          held;
    n  = nib(w);
    mk = wmask(n);
    r  = model(av, bv, sv, mv, cnv, n);
    a = av; b = bv; s = sv; m = mv; cn = cnv;
    start_v[w] = 1'b1;
    @(posedge clk);
    #1;
    start_v[w] = 1'b0;
    a = $urandom; b = $urandom; s = 4'($urandom); m = 1'($urandom); cn = 1'($urandom);
    cyc = 0; busy_cnt = 0; held = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (busy_v[w]) busy_cnt++;
      if (!done_v[w] && f_v[w] !== last_f[w]) held = 1'b0;
      if (poke && cyc == 2) start_v[w] = 1'b1;
      if (poke && cyc == 3) start_v[w] = 1'b0;
    end while (!done_v[w] && cyc < 40);
    start_v[w] = 1'b0;
    check($sformatf("w%0d_latency", w), 64'(cyc), 64'(n + 1));
    check($sformatf("w%0d_busy_cycles", w), 64'(busy_cnt), 64'(n));
    check($sformatf("w%0d_busy_low_at_done", w), 64'(busy_v[w]), 64'd0);
    check($sformatf("w%0d_f_held", w), 64'(held), 64'd1);
    check($sformatf("w%0d_f", w), 64'(f_v[w]), 64'(r[31:0]));
    check($sformatf("w%0d_cn4", w), 64'(cn4_v[w]), 64'(r[32]));
    check($sformatf("w%0d_equal", w), 64'(eq_v[w]), 64'(r[31:0] == mk));
`ifdef ALU181_ZERO_EN
    check($sformatf("w%0d_zero", w), 64'(zero_v[w]), 64'(r[31:0] == 32'd0));
`endif
    last_f[w] = r[31:0];
    if (poke) begin
      extra = 0;
      repeat (n + 3) begin
        @(negedge clk);
        if (done_v[w]) extra++;
      end
      check($sformatf("w%0d_single_done", w), 64'(extra), 64'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w, cnt;
    rst = 1'b1;
    a = '0; b = '0; s = '0; m = 1'b0; cn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      last_f[i]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) begin
      check($sformatf("rst_busy%0d", i), 64'(busy_v[i]), 64'd0);
      check($sformatf("rst_done%0d", i), 64'(done_v[i]), 64'd0);
      check($sformatf("rst_f%0d", i), 64'(f_v[i]), 64'd0);
      check($sformatf("rst_cn4_%0d", i), 64'(cn4_v[i]), 64'd1);
      check($sformatf("rst_equal%0d", i), 64'(eq_v[i]), 64'd0);
`ifdef ALU181_ZERO_EN
      check($sformatf("rst_zero%0d", i), 64'(zero_v[i]), 64'd0);
`endif
    end
    rst = 1'b0;
    @(negedge clk);

    do_op(0, 32'h00FF, 32'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    check("tp_add_f", 64'(f_v[0]), 64'h0100);
    @(negedge clk);
    check("tp_done_one_cycle", 64'(done_v[0]), 64'd0);
    do_op(0, 32'hFFFF, 32'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    check("tp_carry_out", 64'(cn4_v[0]), 64'd0);
    do_op(0, 32'h1234, 32'h1234, 4'b0110, 1'b0, 1'b1, 1'b0);
    check("tp_aeqb", 64'(eq_v[0]), 64'd1);
    do_op(0, 32'h1234, 32'h1234, 4'b0110, 1'b0, 1'b0, 1'b0);
    check("tp_sub_f", 64'(f_v[0]), 64'h0000);
    do_op(0, 32'h1234, 32'h0F0F, 4'b0110, 1'b1, 1'b1, 1'b1);
    check("tp_xor_f", 64'(f_v[0]), 64'h1D3B);
    // back-to-back: second start in the done cycle
    do_op(0, 32'hA5A5, 32'h1111, 4'b1001, 1'b0, 1'b1, 1'b0);
    do_op(0, 32'h0F0F, 32'h00F0, 4'b1110, 1'b1, 1'b1, 1'b0);

    // reset mid-operation
    a = 32'h1234; b = 32'h4321; s = 4'b1001; m = 1'b0; cn = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy_v[0]), 64'd0);
    check("rst_mid_f", 64'(f_v[0]), 64'd0);
    check("rst_mid_cn4", 64'(cn4_v[0]), 64'd1);
    check("rst_mid_done", 64'(done_v[0]), 64'd0);
    start_v[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_v[0] = 1'b0;
    for (int i = 0; i < 3; i++) last_f[i] = '0;
    cnt = 0;
    repeat (7) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) cnt++;
    end
    check("rst_no_done", 64'(cnt), 64'd0);

    do_op(1, 32'h00FF, 32'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    do_op(2, 32'h00FF, 32'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    check("tp8_f", 64'(f_v[2]), 64'h0100);
    do_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 60; k++) begin
      w = $urandom_range(2, 0);
      do_op(w, $urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
            (w != 1) && ($urandom_range(3, 0) == 0));
      if ($urandom_range(1, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu181_serial.md
# alu181_serial

Parametrised, nibble-serial successor to the team's combinational 74181 datapath. The block accepts operands up to 4×NIBBLES bits wide and a start pulse, then ripples one 74181 slice per clock, carrying Cn between slices in a flop. It presents the registered result, final carry and A=B flag with a done pulse. It sits between the input synchronisers and the display decoder, so wide operands cost one slice of logic rather than NIBBLES slices.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices; legal range 1..8; data width W = 4×NIBBLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- a  in  W  operand A, active-high data.
- b  in  W  operand B, active-high data.
- s  in  4  74181 function select.
- m  in  1  mode: 1=logic, 0=arithmetic.
- cn  in  1  carry in, active-low (1 = no carry).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- f  out  W  result, held until next completion.
- cn4  out  1  final carry out, active-low.
- equal  out  1  A=B output: 1 when every bit of f is 1.

## Operation
- States: IDLE, RUN.
- IDLE:
  - On start=1, latch a, b, s, m, cn into operand registers.
  - Set idx=0 and carry=cn, assert busy, go to RUN.
- RUN: each cycle evaluate slice idx on the latched nibbles with carry-in = carry.
  - Write the slice F into accumulator nibble idx; carry <= slice Cn+4; eq_acc <= eq_acc & (&slice F).
  - When idx=NIBBLES-1: copy the accumulator to f, set cn4 = slice Cn+4 and equal = final eq_acc.
  - At that same point pulse done, drop busy and return to IDLE. Otherwise idx++.
- Slice equations are datasheet 74181 (active-high data). Cn+4 = G | (P & Cn) is computed in both modes. In logic mode (m=1) the result is carry-independent, but cn4 is still reported.
- start while busy=1: ignored, no queuing.
- Operand inputs may change freely after the sampling edge.
- f, cn4 and equal change only on the completion edge. Partial results are never visible.
- NIBBLES=1: RUN lasts exactly one cycle.

## Timing
- Reset values: busy=0, done=0, f=0, cn4=1, equal=0, zero=0 (when the macro is defined); internal state IDLE.
- Latency: start is sampled on edge E0. Slices process on E1..E_NIBBLES. done=1 and the new f/cn4/equal appear after E_NIBBLES.
- done is high for exactly one cycle. busy is high from after E0 until after E_NIBBLES.
- Back-to-back: start asserted in the done cycle is accepted (busy=0). Throughput is one operation per NIBBLES+1 cycles.
- Reset mid-operation aborts immediately: no done pulse, and outputs return to reset values.
- start and rst asserted together: rst wins.

## Configuration
- ALU181_ZERO_EN:
  - Defined: adds output port zero (1 bit). zero is 1 when the completed f == 0. It is registered on the completion edge with the other results and resets to 0.
  - Undefined: the port and its logic are absent, and behaviour is otherwise identical.

## Structure
- Package alu181_pkg holds:
  - typedef enum {IDLE, RUN} state;
  - NIBBLE_W=4, MAX_NIBBLES=8;
  - reset constants CN4_RST=1'b1 and EQ_RST=1'b0.
- Sub-module: one instance of the team's existing combinational alu_74181 slice, with P/G left unconnected. The wrapper adds only the sequencer, nibble mux and accumulators.

## Test plan
- NIBBLES=4, a=0x00FF, b=0x0001, s=1001, m=0, cn=1 -> f=0x0100, cn4=1, equal=0. done is high exactly in the cycle after E4, and busy is high for 4 cycles.
- a=0xFFFF, b=0x0001, s=1001, m=0, cn=1 -> f=0x0000, cn4=0 (carry out). zero=1 when ALU181_ZERO_EN is defined.
- a=0x1234, b=0x1234, s=0110, m=0, cn=1 (A minus B minus 1) -> f=0xFFFF, equal=1. Then repeat with cn=0 -> f=0x0000, equal=0.
- m=1, s=0110 (XOR), a=0x1234, b=0x0F0F -> f=0x1D3B. Also drive start again while busy; it is ignored, and exactly one done pulse is seen.
- Back-to-back: assert start in the done cycle with new operands -> second done follows 5 cycles later, and the first f is held until then.
- Assert rst on E2 of an operation -> busy=0, f=0, cn4=1, no done. Repeat the first scenario with NIBBLES=1 and NIBBLES=8 to check the 1-cycle and 8-cycle RUN lengths.
